// File: rtl/audio_frame_arbiter.sv
// audio_frame_arbiter: two-voice frame arbiter feeding an 8-bit PWM sample each 255-cycle frame.
// Optional AUDIO_MIX_EN: accept both voices each frame and output their average.
module audio_frame_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       ch0_valid,
  input  logic [7:0] ch0_sample,
  output logic       ch0_ready,
  input  logic       ch1_valid,
  input  logic [7:0] ch1_sample,
  output logic       ch1_ready,
  output logic [7:0] sample_out,
  output logic       frame_start,
  output logic [1:0] grant,
  output logic       underrun
);
  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;
  state_t state, state_d;
  logic [7:0] cnt;
  logic [7:0] pick;
  logic [1:0] take;
  logic       acc;
  logic       last;
`ifdef AUDIO_MIX_EN
  logic [8:0] sum;
`endif
  always_comb begin
    acc = rst_n && enable && ((state == RUN && cnt == 8'd254) || (state == PRIME && (ch0_valid || ch1_valid)));
    state_d = !enable ? IDLE : state == IDLE ? PRIME : acc ? RUN : state;
`ifdef AUDIO_MIX_EN
    sum = {1'b0, ch0_sample} + {1'b0, ch1_sample};
    take = {ch1_valid, ch0_valid} & {2{acc}};
    pick = &take ? sum[8:1] : take[1] ? ch1_sample : ch0_sample;
`else
    take = {ch1_valid && !(ch0_valid && last), ch0_valid && !(ch1_valid && !last)} & {2{acc}};
    pick = take[1] ? ch1_sample : ch0_sample;
`endif
  end
  assign ch0_ready   = take[0];
  assign ch1_ready   = take[1];
  assign frame_start = state == RUN && cnt == 8'd0;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 8'd254;
      sample_out <= 8'h80;
      grant      <= 2'b00;
      underrun   <= 1'b0;
      last       <= 1'b1;
    end else begin
      state    <= state_d;
      underrun <= acc && take == 2'b00;
      if (!enable || (state != RUN && !acc)) begin
        cnt        <= 8'd254;
        sample_out <= 8'h80;
        grant      <= 2'b00;
      end else if (acc) begin
        cnt   <= 8'd0;
        grant <= take;
        // an empty boundary keeps the previous sample playing
        if (|take) begin
          sample_out <= pick;
          last       <= take[1];
        end
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_audio_frame_arbiter.sv
// tb_audio_frame_arbiter: random stimulus against a frame-level reference model, scoreboard checked.
module tb_audio_frame_arbiter;
  logic       clk = 1'b0;
  logic       rst_n, enable, ch0_valid, ch1_valid, ch0_ready, ch1_ready, frame_start, underrun;
  logic [7:0] ch0_sample, ch1_sample, sample_out;
  logic [1:0] grant;
  typedef struct {
    int s;
    int g;
    int fs;
    int u;
  } exp_t;
  int   q_rdy[$];
  exp_t q_out[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   playing = 0;
  bit   primed = 0;
  int   pos = 0;
  int   last_ch = 1;
  int   samp = 128;
  int   gmask = 0;
  int   und = 0;

  always #5 clk = ~clk;

  audio_frame_arbiter dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .ch0_valid(ch0_valid), .ch0_sample(ch0_sample), .ch0_ready(ch0_ready),
    .ch1_valid(ch1_valid), .ch1_sample(ch1_sample), .ch1_ready(ch1_ready),
    .sample_out(sample_out), .frame_start(frame_start), .grant(grant), .underrun(underrun)
  );

  task automatic chk(string nm, int got, int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, got, want, $time);
    end
  endtask

  // one clock of stimulus; the model predicts ready now and the registered outputs after the edge
  task automatic cyc(bit r, bit e, bit a, bit b, logic [7:0] x, logic [7:0] y);
    int  mask;
    bit  boundary;
    @(negedge clk);
    rst_n = r; enable = e; ch0_valid = a; ch1_valid = b; ch0_sample = x; ch1_sample = y;
    mask = 0;
    if (!r) begin
      playing = 0; primed = 0; pos = 0; last_ch = 1; samp = 128; gmask = 0; und = 0;
    end else if (!e) begin
      playing = 0; primed = 0; pos = 0; samp = 128; gmask = 0; und = 0;
    end else begin
      boundary = playing ? pos == 254 : primed && (a || b);
      if (boundary) begin
`ifdef AUDIO_MIX_EN
        mask = {30'd0, b, a};
`else
        mask = (a && b) ? (last_ch == 0 ? 2 : 1) : a ? 1 : b ? 2 : 0;
`endif
        playing = 1; primed = 0; pos = 0; gmask = mask; und = mask == 0;
        if (mask == 3) samp = (int'(x) + int'(y)) / 2;
        else if (mask == 1) samp = x;
        else if (mask == 2) samp = y;
        if (mask == 1) last_ch = 0;
        if (mask == 2) last_ch = 1;
      end else begin
        und = 0;
        if (playing) pos++;
        else primed = 1;
      end
    end
    q_rdy.push_back(mask);
    q_out.push_back('{samp, gmask, (playing && pos == 0) ? 1 : 0, und});
  endtask

  always begin
    exp_t e;
    @(negedge clk);
    #1;
    if (q_rdy.size() > 0) chk("ready", {ch1_ready, ch0_ready}, q_rdy.pop_front());
    @(posedge clk);
    #1;
    if (q_out.size() > 0) begin
      e = q_out.pop_front();
      chk("sample_out", sample_out, e.s);
      chk("grant", grant, e.g);
      chk("frame_start", frame_start, e.fs);
      chk("underrun", underrun, e.u);
    end
  end

  initial begin
    bit en;
    rst_n = 0; enable = 0; ch0_valid = 0; ch1_valid = 0; ch0_sample = 0; ch1_sample = 0;
    repeat (3) cyc(0, 0, 0, 0, 8'h00, 8'h00);
    // continuous contention: alternating grants starting at ch0
    cyc(1, 1, 0, 0, 8'h00, 8'h00);
    repeat (800) cyc(1, 1, 1, 1, 8'h10, 8'hF0);
    // valids gone: underrun with held sample
    repeat (300) cyc(1, 1, 0, 0, 8'h00, 8'h00);
    // enable drop mid-frame, then re-enable with a single voice
    repeat (100) cyc(1, 1, 0, 1, 8'h00, 8'h33);
    repeat (3) cyc(1, 0, 1, 1, 8'h11, 8'h22);
    repeat (4) cyc(1, 1, 0, 0, 8'h00, 8'h00);
    repeat (300) cyc(1, 1, 1, 0, 8'h40, 8'h00);
    // mid-run reset: next contention must go to ch0
    repeat (50) cyc(1, 1, 1, 1, 8'hFF, 8'hFF);
    repeat (2) cyc(0, 1, 1, 1, 8'h01, 8'h02);
    repeat (600) cyc(1, 1, 1, 1, 8'h01, 8'h02);
    en = 1;
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 999) == 0) en = ~en;
      if (!en && $urandom_range(0, 9) == 0) en = 1;
      cyc($urandom_range(0, 1999) != 0, en, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7,
          8'($urandom), 8'($urandom));
    end
    @(posedge clk);
    #3;
    chk("drain", q_rdy.size() + q_out.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
